mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter sharing the single 32-bit memory port between the instruction-fetch requester (port 0) and the load/store requester (port 1). It drives the select of the 32-bit 2-to-1 address mux in front of memory, registers the winning request, waits for memory completion with a watchdog, and returns read data with a one-cycle done pulse. Round-robin priority on simultaneous requests prevents starvation of either port.

## Interface
- WIDTH, 32, data and address width
- TIMEOUT, 16, max BUSY cycles waiting for mem_ready before error completion (≥2)
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0  in  1  fetch request; held high until done0
- addr0  in  WIDTH  fetch address (read only)
- req1  in  1  load/store request; held high until done1
- addr1  in  WIDTH  data address
- we1  in  1  1 = store, 0 = load
- wdata1  in  WIDTH  store data
- mem_ready  in  1  memory completed current access this cycle
- mem_rdata  in  WIDTH  memory read data, valid with mem_ready
- mem_sel  out  1  address mux select: 0 = port 0, 1 = port 1
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  WIDTH  latched address of granted port
- mem_wdata  out  WIDTH  latched store data
- done0, done1  out  1  one-cycle completion pulse per port
- rdata  out  WIDTH  read data, valid while done0/done1 high
- err  out  1  high with done pulse when completion was by timeout

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: no request -> stay. One request -> grant it. Both -> grant port opposite to last_gnt; last_gnt updates to winner.
- Grant (IDLE->BUSY): latch mem_sel=winner, mem_addr=addr of winner, mem_we=we1 if port 1 else 0, mem_wdata=wdata1 if port 1 else 0; mem_en=1; clear wait counter.
- BUSY: mem_ready=1 -> rdata<=mem_rdata (port 0 or load; stores leave rdata unchanged), err<=0, go DONE. Else counter increments; counter reaching TIMEOUT-1 without mem_ready -> rdata<=0, err<=1, go DONE.
- DONE: mem_en=0, mem_we=0; done of granted port =1 for exactly this cycle; next state IDLE unconditionally.
- Request inputs, addresses and data are sampled only in IDLE; changes or req drop during BUSY/DONE are ignored, access completes.
- mem_sel, mem_addr, mem_wdata hold last values outside BUSY.
- Counter width: ceil(log2(TIMEOUT)) bits; never wraps (state leaves BUSY first).
- mem_ready outside BUSY ignored.

## Timing
- Reset (async assert, sync to clk on release): state=IDLE, mem_en=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, done0=done1=0, rdata=0, err=0, last_gnt=1 (port 0 wins first tie).
- All outputs registered; no combinational input-to-output path.
- Request at IDLE edge N -> mem_en high from N+1. mem_ready seen at edge M -> done high cycle M+1 only, IDLE at M+2.
- Minimum transaction: 3 cycles (IDLE, BUSY with mem_ready, DONE); next grant earliest cycle after DONE.
- Requester must drop req in cycle after done; req still high in the following IDLE is a new request.
- Timeout: mem_en high exactly TIMEOUT cycles, then DONE with err=1.
- reset_n low mid-BUSY/DONE: access abandoned, no done pulse, all outputs to reset values immediately.

## Test plan
- Reset: reset_n=0 mid-BUSY -> mem_en=0, done0=done1=0, rdata=0 immediately; after release first tie grants port 0.
- Single fetch: req0=1, addr0=0x0000_0040, mem_ready after 2 BUSY cycles with mem_rdata=0x8C01_0004 -> mem_sel=0, mem_addr=0x40, done0 one cycle, rdata=0x8C01_0004, err=0.
- Store: req1=1, we1=1, addr1=0x1000, wdata1=0xDEAD_BEEF -> mem_sel=1, mem_we=1, mem_wdata=0xDEAD_BEEF during BUSY, done1 pulse, rdata unchanged.
- Contention: req0 and req1 high continuously, immediate mem_ready -> grants alternate 0,1,0,1; each done separated by 3 cycles.
- Timeout: TIMEOUT=16, req1 load, mem_ready never -> mem_en high 16 cycles, done1 with err=1, rdata=0.
- Mid-access change: addr0 changed and req0 dropped during BUSY -> mem_addr holds original, done0 still pulses once.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single shared memory port: fetch (port 0) vs load/store (port 1).
// Round-robin on ties, registered access with a completion watchdog, one-cycle done pulse per port.
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] addr0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr1,
  input  logic             we1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_sel,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] rdata,
  output logic             err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last_gnt;
  logic [CW-1:0]   r_cnt;
  logic            w_grant;
  logic            w_winner;
  logic            w_finish;
  logic            w_timeout;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next    = r_state;
    w_grant   = 1'b0;
    w_winner  = 1'b0;
    w_finish  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_grant  = 1'b1;
          // On a tie the port that did not win last time goes first.
          w_winner = (req0 && req1) ? ~r_last_gnt : req1;
          w_next   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          w_finish = 1'b1;
          w_next   = S_DONE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_finish  = 1'b1;
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b1;
      r_cnt      <= '0;
      mem_sel    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      r_state <= w_next;
      done0   <= 1'b0;
      done1   <= 1'b0;

      if (w_grant) begin
        r_last_gnt <= w_winner;
        mem_sel    <= w_winner;
        mem_addr   <= w_winner ? addr1 : addr0;
        mem_we     <= w_winner & we1;
        mem_wdata  <= w_winner ? wdata1 : '0;
        mem_en     <= 1'b1;
        r_cnt      <= '0;
      end

      if (r_state == S_BUSY && !w_finish) begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_finish) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        done0  <= ~mem_sel;
        done1  <= mem_sel;
        err    <= w_timeout;
        // Stores leave the previous read data visible; a timeout always returns zero.
        if (w_timeout) begin
          rdata <= '0;
        end else if (!mem_we) begin
          rdata <= mem_rdata;
        end
      end

      if (r_state == S_DONE) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: requester tasks push expected completions,
// a negedge monitor checks grants and done pulses, a bench memory answers with random latency.
module tb_mem_port_arbiter;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  logic             clk;
  logic             reset_n;
  logic             req0;
  logic [WIDTH-1:0] addr0;
  logic             req1;
  logic [WIDTH-1:0] addr1;
  logic             we1;
  logic [WIDTH-1:0] wdata1;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_sel;
  logic             mem_en;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] rdata;
  logic             err;

  mem_port_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0      (req0),
    .addr0     (addr0),
    .req1      (req1),
    .addr1     (addr1),
    .we1       (we1),
    .wdata1    (wdata1),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_sel   (mem_sel),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done0     (done0),
    .done1     (done1),
    .rdata     (rdata),
    .err       (err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];

  int n_checks = 0;
  int n_pass   = 0;
  int force_lat = -1;
  int cyc = 0;

  logic g_req0 = 1'b0;
  logic g_req1 = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : hash(a);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : hash(a);
  endfunction

  // Request sampling at the edge the DUT arbitrates on.
  initial forever begin
    @(posedge clk);
    g_req0 = req0;
    g_req1 = req1;
    cyc++;
  end

  // Bench memory: addresses with [1:0]==3 never answer; otherwise random latency.
  // Outside an access it toggles mem_ready randomly, which the DUT must ignore.
  initial begin
    bit rsp_active;
    int rsp_cnt;
    int rsp_lat;
    rsp_active = 1'b0;
    rsp_cnt = 0;
    rsp_lat = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (reset_n && mem_en) begin
        if (!rsp_active) begin
          rsp_active = 1'b1;
          rsp_cnt = 0;
          rsp_lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 5);
        end
        if (mem_addr[1:0] != 2'b11 && rsp_cnt == rsp_lat) begin
          mem_ready = 1'b1;
          if (mem_we) bus_mem[mem_addr] = mem_wdata;
          else mem_rdata = bus_rd(mem_addr);
        end
        rsp_cnt++;
      end else begin
        rsp_active = 1'b0;
        mem_ready = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // Monitor: checks every grant against the arbitration rule and every done against the scoreboard.
  initial begin
    logic        prev_en, prev_done, prev_ready, model_last, w;
    logic [31:0] last_rdata, exp_rd;
    int          en_len;
    exp_t        e;
    prev_en = 0; prev_done = 0; prev_ready = 0; model_last = 1; w = 0;
    last_rdata = '0; exp_rd = '0; en_len = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_en = 0; prev_done = 0; prev_ready = 0; en_len = 0;
        model_last = 1'b1;
        last_rdata = '0;
      end else begin
        if (mem_en && !prev_en) begin
          en_len = 1;
          if (!g_req0 && !g_req1) begin
            check("spurious_grant", 1, 0);
          end else begin
            w = (g_req0 && g_req1) ? ~model_last : g_req1;
            model_last = w;
            check("grant_sel", {31'b0, mem_sel}, {31'b0, w});
            if (w ? (q1.size() == 0) : (q0.size() == 0)) begin
              check("grant_without_request", 1, 0);
            end else begin
              e = w ? q1[0] : q0[0];
              check("grant_addr", mem_addr, e.addr);
              check("grant_we", {31'b0, mem_we}, {31'b0, e.we});
              check("grant_wdata", mem_wdata, e.wdata);
            end
          end
        end else if (mem_en) begin
          en_len++;
        end

        if (done0 && done1) begin
          check("both_done", 1, 0);
        end else if (done0 || done1) begin
          check("done_single_cycle", {31'b0, prev_done}, 0);
          check("done_mem_en_low", {31'b0, mem_en}, 0);
          if (done1 ? (q1.size() == 0) : (q0.size() == 0)) begin
            check("done_without_request", 1, 0);
          end else begin
            e = done1 ? q1.pop_front() : q0.pop_front();
            if (e.err) check("timeout_en_cycles", en_len, TIMEOUT);
            else check("done_after_ready", {31'b0, prev_ready}, 1);
            exp_rd = e.err ? 32'h0 : (e.we ? last_rdata : e.rdata);
            check(done1 ? "rdata_p1" : "rdata_p0", rdata, exp_rd);
            check("err", {31'b0, err}, {31'b0, e.err});
            last_rdata = exp_rd;
          end
        end
        prev_en = mem_en;
        prev_done = done0 || done1;
        prev_ready = mem_ready;
      end
    end
  end

  // One access from port p: predicts the completion, holds req until done, drops it the cycle after.
  task automatic txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic pert);
    exp_t e;
    logic hang, done_seen, perturbed;
    int   n;
    hang = (a[1:0] == 2'b11);
    e.we = (p == 1) && we;
    e.addr = a;
    e.wdata = (p == 1) ? d : 32'h0;
    e.err = hang;
    e.rdata = hang ? 32'h0 : ref_rd(a);
    if (e.we && !hang) ref_mem[a] = d;
    if (p == 0) begin
      addr0 = a; req0 = 1'b1; q0.push_back(e);
    end else begin
      addr1 = a; we1 = we; wdata1 = d; req1 = 1'b1; q1.push_back(e);
    end
    n = 0; done_seen = 0; perturbed = 0;
    while (!done_seen && n < 200) begin
      @(negedge clk);
      n++;
      if (pert && !perturbed && mem_en && (int'(mem_sel) == p)) begin
        perturbed = 1'b1;
        if (p == 0) begin
          addr0 = ~a; req0 = 1'b0;
        end else begin
          addr1 = ~a; wdata1 = ~d; we1 = ~we; req1 = 1'b0;
        end
      end
      done_seen = (p == 0) ? done0 : done1;
    end
    check(p == 0 ? "done0_seen" : "done1_seen", {31'b0, done_seen}, 1);
    @(posedge clk);
    #1;
    if (p == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic run_port(input int p, input int n, input int max_gap, input int hang_pct,
                          input int pert_pct);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, d;
      logic        we, hang;
      if (i > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      hang = ($urandom_range(0, 99) < hang_pct);
      d = $urandom;
      we = (p == 1) && ($urandom_range(0, 1) == 1);
      a = (p == 0) ? ($urandom & 32'h0000_0FFF) : (32'h1000_0000 | ($urandom & 32'h0000_003C));
      if (hang) a[1:0] = 2'b11;
      else if (a[1:0] == 2'b11) a[1:0] = 2'b00;
      txn(p, we, a, d, ($urandom_range(0, 99) < pert_pct));
    end
  endtask

  initial begin
    int n, last_cyc;
    reset_n = 1'b0;
    req0 = 0; addr0 = '0; req1 = 0; addr1 = '0; we1 = 0; wdata1 = '0;
    #13;
    check("rst_mem_en", {31'b0, mem_en}, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    check("rst_mem_sel", {31'b0, mem_sel}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_done0", {31'b0, done0}, 0);
    check("rst_done1", {31'b0, done1}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", {31'b0, err}, 0);
    #9 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch with known memory contents.
    ref_mem[32'h40] = 32'h8C01_0004;
    bus_mem[32'h40] = 32'h8C01_0004;
    force_lat = 2;
    txn(0, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
    // Store: rdata must keep the fetched word.
    txn(1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);

    // Contention with immediate memory: grants alternate starting with port 0, dones 3 cycles apart.
    force_lat = 0;
    last_cyc = 0;
    fork
      run_port(0, 4, 0, 0, 0);
      run_port(1, 4, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
        n = 0;
        do begin @(negedge clk); n++; end while (!(done0 || done1) && n < 50);
        check("contention_done_seen", {31'b0, (done0 || done1)}, 1);
        check("contention_order", {31'b0, done1}, 32'(k % 2));
        if (k > 0) check("contention_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
      end
    join

    // Address change and req drop while busy: the latched address still completes.
    force_lat = 3;
    txn(0, 1'b0, 32'h0000_0080, 32'h0, 1'b1);
    force_lat = -1;

    // Reset in the middle of a (never-answered) access.
    addr0 = 32'h0000_0043;
    req0 = 1'b1;
    q0.push_back('{we: 1'b0, addr: 32'h0000_0043, wdata: 32'h0, rdata: 32'h0, err: 1'b1});
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_en && n < 20);
    check("busy_before_reset", {31'b0, mem_en}, 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_mem_en", {31'b0, mem_en}, 0);
    check("midrst_done0", {31'b0, done0}, 0);
    check("midrst_done1", {31'b0, done1}, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_err", {31'b0, err}, 0);
    check("midrst_mem_addr", mem_addr, 0);
    req0 = 1'b0;
    q0.delete();
    repeat (2) @(negedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic; both ports request together first, so port 0 must win that tie.
    fork
      run_port(0, 40, 3, 10, 15);
      run_port(1, 40, 3, 10, 15);
    join

    // Watchdog completion on a port-1 load.
    txn(1, 1'b0, 32'h1000_0013, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
